// File: rtl/simple_nbit_cpu.sv
// Two-cycle (FETCH/EXEC) multicycle CPU with four DW-bit registers, Z/C flags
// and a 2**AW x 16 program memory that is loaded only while stopped.
module simple_nbit_cpu #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    output logic [DW-1:0] R0,
    output logic [DW-1:0] R1,
    output logic [DW-1:0] R2,
    output logic [DW-1:0] R3,
    output logic [AW-1:0] pc,
    output logic [15:0]   instr,
    output logic          zero,
    output logic          carry,
    output logic          busy,
    output logic          halt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_MOV = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9,
        OP_JMP = 4'hA,
        OP_JZ  = 4'hB,
        OP_JC  = 4'hC,
        OP_HLT = 4'hF
    } opcode_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   regs_q [4];
    logic [DW-1:0]   regs_d [4];
    logic [AW-1:0]   pc_q, pc_d;
    logic [15:0]     instr_q, instr_d;
    logic            zero_q, zero_d;
    logic            carry_q, carry_d;
    logic [15:0]     mem_q [DEPTH];
    logic            mem_we;

    opcode_t         op;
    logic [1:0]      rd, rs;
    logic [DW-1:0]   a, b, imm_ext;
    logic [DW:0]     sum;
    logic [DW-1:0]   alu_res;
    logic            alu_c;
    logic            alu_wr;
    logic            alu_zupd;
    logic            alu_cupd;
    logic            jump_taken;

    assign op      = opcode_t'(instr_q[15:12]);
    assign rd      = instr_q[11:10];
    assign rs      = instr_q[9:8];
    // Size cast zero-extends for DW>8 and keeps the low DW bits for DW<8.
    assign imm_ext = DW'(instr_q[7:0]);
    assign a       = regs_q[rd];
    assign b       = regs_q[rs];
    assign sum     = {1'b0, a} + {1'b0, b};

    always_comb begin
        alu_res    = '0;
        alu_c      = carry_q;
        alu_wr     = 1'b0;
        alu_zupd   = 1'b0;
        alu_cupd   = 1'b0;
        jump_taken = 1'b0;
        case (op)
            OP_LDI: begin
                alu_res  = imm_ext;
                alu_wr   = 1'b1;
                alu_zupd = 1'b1;
            end
            OP_MOV: begin
                alu_res = b;
                alu_wr  = 1'b1;
            end
            OP_ADD: begin
                alu_res  = sum[DW-1:0];
                alu_c    = sum[DW];
                alu_wr   = 1'b1;
                alu_zupd = 1'b1;
                alu_cupd = 1'b1;
            end
            OP_SUB: begin
                alu_res  = a - b;
                alu_c    = (a < b);
                alu_wr   = 1'b1;
                alu_zupd = 1'b1;
                alu_cupd = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (op == OP_AND)
                    alu_res = a & b;
                else if (op == OP_OR)
                    alu_res = a | b;
                else
                    alu_res = a ^ b;
                alu_c    = 1'b0;
                alu_wr   = 1'b1;
                alu_zupd = 1'b1;
                alu_cupd = 1'b1;
            end
            OP_SHL: begin
                alu_res  = {a[DW-2:0], 1'b0};
                alu_c    = a[DW-1];
                alu_wr   = 1'b1;
                alu_zupd = 1'b1;
                alu_cupd = 1'b1;
            end
            OP_SHR: begin
                alu_res  = {1'b0, a[DW-1:1]};
                alu_c    = a[0];
                alu_wr   = 1'b1;
                alu_zupd = 1'b1;
                alu_cupd = 1'b1;
            end
            OP_JMP: jump_taken = 1'b1;
            OP_JZ:  jump_taken = zero_q;
            OP_JC:  jump_taken = carry_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        mem_we  = 1'b0;
        for (int unsigned i = 0; i < 4; i++)
            regs_d[i] = regs_q[i];
        case (state_q)
            S_IDLE, S_HALTED: begin
                mem_we = prog_we;
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                instr_d = mem_q[pc_q];
                pc_d    = pc_q + 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = (op == OP_HLT) ? S_HALTED : S_FETCH;
                if (alu_wr)
                    regs_d[rd] = alu_res;
                if (alu_zupd)
                    zero_d = (alu_res == '0);
                if (alu_cupd)
                    carry_d = alu_c;
                if (jump_taken)
                    pc_d = instr_q[AW-1:0];
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            for (int unsigned i = 0; i < 4; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    // Program memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[prog_addr] <= prog_data;
    end

    assign R0    = regs_q[0];
    assign R1    = regs_q[1];
    assign R2    = regs_q[2];
    assign R3    = regs_q[3];
    assign pc    = pc_q;
    assign instr = instr_q;
    assign zero  = zero_q;
    assign carry = carry_q;
    assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halt  = (state_q == S_HALTED);

endmodule
